jtag_tap_mc: RTL and testbench

Parametrised IEEE 1149.1 TAP controller for the debug transport module. It fixes BYPASS, IDCODE and DTMCS internally, and routes `NumChannels` external data registers (DMI access, plus future trace/user chains) through one TAP. The block sits between the JTAG pads and the DMI/user-chain shift logic, all in the `tck_i` domain. It adds two things over the single-DMI TAP: single-cycle `dmireset`/`dmihardreset` pulses and a standards-conformant Test-Logic-Reset entry.

---
 rtl/jtag_tap_pkg.sv | 38 +++
 rtl/jtag_tap_fsm.sv | 56 +++++
 rtl/jtag_tap_mc.sv | 169 ++++++++++++++++
 tb/tb_jtag_tap_mc.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared types and IR constants for the multi-channel JTAG TAP.
// State encoding is fixed so other logic can decode it without a lookup.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TestLogicReset = 4'd0,
    RunTestIdle    = 4'd1,
    SelectDr       = 4'd2,
    CaptureDr      = 4'd3,
    ShiftDr        = 4'd4,
    Exit1Dr        = 4'd5,
    PauseDr        = 4'd6,
    Exit2Dr        = 4'd7,
    UpdateDr       = 4'd8,
    SelectIr       = 4'd9,
    CaptureIr      = 4'd10,
    ShiftIr        = 4'd11,
    Exit1Ir        = 4'd12,
    PauseIr        = 4'd13,
    Exit2Ir        = 4'd14,
    UpdateIr       = 4'd15
  } tap_state_e;

  typedef struct packed {
    logic [31:18] zero1;
    logic         dmihardreset;
    logic         dmireset;
    logic         zero0;
    logic [2:0]   idle;
    logic [1:0]   dmistat;
    logic [5:0]   abits;
    logic [3:0]   version;
  } dtmcs_t;

  localparam logic [7:0] BYPASS0 = 8'h00;
  localparam logic [7:0] IDCODE  = 8'h01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 1149.1 TAP state machine with one-hot-per-visit strobes decoded
// straight from the state register.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic tck_i,
  input  logic trst_ni,
  input  logic tms_i,
  output logic test_logic_reset_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic capture_ir_o,
  output logic shift_ir_o,
  output logic update_ir_o
);

  tap_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms_i ? SelectDr       : RunTestIdle;
      SelectDr:       state_d = tms_i ? SelectIr       : CaptureDr;
      CaptureDr:      state_d = tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms_i ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms_i ? SelectDr       : RunTestIdle;
      SelectIr:       state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms_i ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms_i ? SelectDr       : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) state_q <= TestLogicReset;
    else          state_q <= state_d;
  end

  assign test_logic_reset_o = (state_q == TestLogicReset);
  assign capture_dr_o       = (state_q == CaptureDr);
  assign shift_dr_o         = (state_q == ShiftDr);
  assign update_dr_o        = (state_q == UpdateDr);
  assign capture_ir_o       = (state_q == CaptureIr);
  assign shift_ir_o         = (state_q == ShiftIr);
  assign update_ir_o        = (state_q == UpdateIr);

endmodule

// File: rtl/jtag_tap_mc.sv
// TAP with internal BYPASS/IDCODE/DTMCS and NumChannels external DR chains.
// TDO is relaunched on the falling edge so the probe samples it mid-cycle.
module jtag_tap_mc
  import jtag_tap_pkg::*;
#(
  parameter int unsigned IrLength    = 5,
  parameter logic [31:0] IdcodeValue = 32'h0000_0001,
  parameter int unsigned NumChannels = 1,
  parameter int unsigned IrDtmcs     = 'h10,
  parameter int unsigned IrChanBase  = 'h11,
  parameter int unsigned Abits       = 7,
  parameter int unsigned IdleHint    = 1
) (
  input  logic                   tck_i,
  input  logic                   trst_ni,
  input  logic                   tms_i,
  input  logic                   td_i,
  output logic                   td_o,
  output logic                   tdo_oe_o,
  output logic                   test_logic_reset_o,
  output logic                   capture_dr_o,
  output logic                   shift_dr_o,
  output logic                   update_dr_o,
  output logic [NumChannels-1:0] chan_select_o,
  output logic                   dr_tdi_o,
  input  logic [NumChannels-1:0] chan_tdo_i,
  input  logic [1:0]             dmistat_i,
  output logic                   dmireset_o,
  output logic                   dmihardreset_o
);

  localparam logic [IrLength-1:0] IrIdcode  = IrLength'(IDCODE);
  localparam logic [IrLength-1:0] IrBypass0 = IrLength'(BYPASS0);
  localparam logic [IrLength-1:0] IrDtmcsW  = IrLength'(IrDtmcs);
  localparam logic [5:0]          AbitsW    = 6'(Abits);
  localparam logic [2:0]          IdleW     = 3'(IdleHint);

  logic tlr, capture_ir, shift_ir, update_ir;

  jtag_tap_fsm u_fsm (
    .tck_i              (tck_i),
    .trst_ni            (trst_ni),
    .tms_i              (tms_i),
    .test_logic_reset_o (tlr),
    .capture_dr_o       (capture_dr_o),
    .shift_dr_o         (shift_dr_o),
    .update_dr_o        (update_dr_o),
    .capture_ir_o       (capture_ir),
    .shift_ir_o         (shift_ir),
    .update_ir_o        (update_ir)
  );

  logic [IrLength-1:0]    ir_shift_q, ir_shift_d, ir_q, ir_d;
  logic [31:0]            idcode_q, idcode_d;
  logic                   bypass_q, bypass_d;
  dtmcs_t                 dtmcs_q, dtmcs_d, dtmcs_capture;
  logic                   dmireset_q, dmireset_d, dmihardreset_q, dmihardreset_d;
  logic                   sel_idcode, sel_dtmcs;
  logic [NumChannels-1:0] chan_sel;
  logic                   tdo_mux, td_q, tdo_oe_q;

  always_comb begin
    ir_shift_d = ir_shift_q;
    ir_d       = ir_q;
    if (tlr) begin
      ir_shift_d = '0;
      ir_d       = IrIdcode;
    end else begin
      if (capture_ir) ir_shift_d = IrLength'(2'b01);
      if (shift_ir)   ir_shift_d = {td_i, ir_shift_q[IrLength-1:1]};
      if (update_ir)  ir_d       = ir_shift_q;
    end
  end

  // Unlisted codes, including 0 and all-ones, fall through to BYPASS.
  always_comb begin
    sel_idcode = 1'b0;
    sel_dtmcs  = 1'b0;
    chan_sel   = '0;
    if (ir_q == IrIdcode) begin
      sel_idcode = 1'b1;
    end else if (ir_q == IrDtmcsW) begin
      sel_dtmcs = 1'b1;
    end else if (ir_q != IrBypass0 && ir_q != '1) begin
      for (int k = 0; k < int'(NumChannels); k++) begin
        if (ir_q == IrLength'(IrChanBase + 32'(k))) chan_sel[k] = 1'b1;
      end
    end
  end

  always_comb begin
    dtmcs_capture         = '0;
    dtmcs_capture.idle    = IdleW;
    dtmcs_capture.dmistat = dmistat_i;
    dtmcs_capture.abits   = AbitsW;
    dtmcs_capture.version = 4'd1;
  end

  always_comb begin
    idcode_d       = idcode_q;
    bypass_d       = bypass_q;
    dtmcs_d        = dtmcs_q;
    dmireset_d     = 1'b0;
    dmihardreset_d = 1'b0;
    if (tlr) begin
      idcode_d = IdcodeValue;
      bypass_d = 1'b0;
      dtmcs_d  = '0;
    end else if (capture_dr_o) begin
      idcode_d = IdcodeValue;
      bypass_d = 1'b0;
      dtmcs_d  = dtmcs_capture;
    end else if (shift_dr_o) begin
      if (sel_idcode)          idcode_d = {td_i, idcode_q[31:1]};
      else if (sel_dtmcs)      dtmcs_d  = {td_i, dtmcs_q[31:1]};
      else if (chan_sel == '0) bypass_d = td_i;
    end else if (update_dr_o && sel_dtmcs) begin
      dmireset_d     = dtmcs_q.dmireset;
      dmihardreset_d = dtmcs_q.dmihardreset;
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_shift_q     <= '0;
      ir_q           <= IrIdcode;
      idcode_q       <= IdcodeValue;
      bypass_q       <= 1'b0;
      dtmcs_q        <= '0;
      dmireset_q     <= 1'b0;
      dmihardreset_q <= 1'b0;
    end else begin
      ir_shift_q     <= ir_shift_d;
      ir_q           <= ir_d;
      idcode_q       <= idcode_d;
      bypass_q       <= bypass_d;
      dtmcs_q        <= dtmcs_d;
      dmireset_q     <= dmireset_d;
      dmihardreset_q <= dmihardreset_d;
    end
  end

  always_comb begin
    tdo_mux = bypass_q;
    if (shift_ir)        tdo_mux = ir_shift_q[0];
    else if (sel_idcode) tdo_mux = idcode_q[0];
    else if (sel_dtmcs)  tdo_mux = dtmcs_q[0];
    else if (|chan_sel)  tdo_mux = |(chan_sel & chan_tdo_i);
  end

  always_ff @(negedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      td_q     <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      td_q     <= tlr ? 1'b0 : tdo_mux;
      tdo_oe_q <= shift_ir | shift_dr_o;
    end
  end

  assign td_o               = td_q;
  assign tdo_oe_o           = tdo_oe_q;
  assign test_logic_reset_o = tlr;
  assign chan_select_o      = chan_sel;
  assign dr_tdi_o           = td_i;
  assign dmireset_o         = dmireset_q;
  assign dmihardreset_o     = dmihardreset_q;

endmodule

// File: tb/tb_jtag_tap_mc.sv
// Directed and randomized scans of jtag_tap_mc with two external channels,
// checked against a register-level model of what each IR selects.
module tb_jtag_tap_mc;

  localparam int IR_LEN = 5;

  logic       tck_i = 1'b0;
  logic       trst_ni = 1'b0;
  logic       tms_i = 1'b1;
  logic       td_i = 1'b0;
  logic       td_o, tdo_oe_o, test_logic_reset_o;
  logic       capture_dr_o, shift_dr_o, update_dr_o, dr_tdi_o;
  logic [1:0] chan_select_o;
  logic [1:0] chan_tdo_i = 2'b00;
  logic [1:0] dmistat_i = 2'b00;
  logic       dmireset_o, dmihardreset_o;

  int checks = 0;
  int errors = 0;
  logic [1:0] chan_seen [64];

  jtag_tap_mc #(.NumChannels(2)) dut (
    .tck_i              (tck_i),
    .trst_ni            (trst_ni),
    .tms_i              (tms_i),
    .td_i               (td_i),
    .td_o               (td_o),
    .tdo_oe_o           (tdo_oe_o),
    .test_logic_reset_o (test_logic_reset_o),
    .capture_dr_o       (capture_dr_o),
    .shift_dr_o         (shift_dr_o),
    .update_dr_o        (update_dr_o),
    .chan_select_o      (chan_select_o),
    .dr_tdi_o           (dr_tdi_o),
    .chan_tdo_i         (chan_tdo_i),
    .dmistat_i          (dmistat_i),
    .dmireset_o         (dmireset_o),
    .dmihardreset_o     (dmihardreset_o)
  );

  always #5 tck_i = ~tck_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One TCK: inputs applied after a falling edge, returns just after the next one.
  task automatic step(input logic tms, input logic tdi);
    tms_i = tms;
    td_i = tdi;
    chan_tdo_i = 2'($urandom);
    @(posedge tck_i);
    #1;
    @(negedge tck_i);
    #1;
  endtask

  // Reference model: what a DR scan captures for a given IR.
  function automatic int dr_len(input logic [4:0] ir);
    return (ir == 5'h01 || ir == 5'h10) ? 32 : 1;
  endfunction

  function automatic logic [31:0] dr_cap(input logic [4:0] ir, input logic [1:0] st);
    if (ir == 5'h01) return 32'h0000_0001;
    if (ir == 5'h10) return (32'd1 << 12) + (32'(st) << 10) + (32'd7 << 4) + 32'd1;
    return 32'h0;
  endfunction

  function automatic logic [1:0] chan_model(input logic [4:0] ir);
    if (ir == 5'h11) return 2'b01;
    if (ir == 5'h12) return 2'b10;
    return 2'b00;
  endfunction

  task automatic scan_ir(input logic [4:0] ir, output logic [4:0] tdo);
    tdo = '0;
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    tdo[0] = td_o;
    for (int i = 0; i < IR_LEN; i++) begin
      step(i == IR_LEN - 1, ir[i]);
      if (i < IR_LEN - 1) tdo[i+1] = td_o;
    end
    step(1, 0);
    step(0, 0);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] tdi, input int pause_at,
                         output logic [63:0] tdo);
    tdo = '0;
    step(1, 0);
    step(0, 0);
    chk("capture_dr", capture_dr_o, 1);
    step(0, 0);
    chk("shift_dr", shift_dr_o, 1);
    chk("oe_shift", tdo_oe_o, 1);
    tdo[0] = td_o;
    chan_seen[0] = chan_tdo_i;
    for (int i = 0; i < n; i++) begin
      step((i == n - 1) || (pause_at > 0 && i == pause_at - 1), tdi[i]);
      if (pause_at > 0 && i == pause_at - 1 && i != n - 1) begin
        step(0, 0);
        chk("oe_pause", tdo_oe_o, 0);
        step(1, 0);
        step(0, 0);
      end
      if (i < n - 1) begin
        tdo[i+1] = td_o;
        chan_seen[i+1] = chan_tdo_i;
      end
    end
    step(1, 0);
    chk("update_dr", update_dr_o, 1);
    chk("pulse_in_update", {dmireset_o, dmihardreset_o}, 2'b00);
    step(0, 0);
  endtask

  initial begin
    logic [4:0]  irtdo;
    logic [63:0] tdo, tdi, exp, mask;
    logic [4:0]  ir;
    logic [31:0] cap;
    int n, len, pause_at;

    // Held in reset
    #12;
    chk("rst_tlr", test_logic_reset_o, 1);
    chk("rst_tdo", td_o, 0);
    chk("rst_oe", tdo_oe_o, 0);
    chk("rst_pulses", {dmireset_o, dmihardreset_o}, 2'b00);
    chk("rst_chan_sel", chan_select_o, 2'b00);
    @(negedge tck_i);
    #1;
    trst_ni = 1'b1;
    step(0, 0);
    chk("rti_tlr_low", test_logic_reset_o, 0);
    chk("rti_oe", tdo_oe_o, 0);

    // IDCODE selected after reset
    scan_dr(32, 64'h0, 0, tdo);
    chk("idcode_read", tdo[31:0], 32'h0000_0001);
    chk("oe_after_scan", tdo_oe_o, 0);

    // DTMCS read
    scan_ir(5'h10, irtdo);
    chk("ir_capture", irtdo, 5'b00001);
    chk("dtmcs_chan_sel", chan_select_o, 2'b00);
    dmistat_i = 2'b00;
    scan_dr(32, 64'h0, 0, tdo);
    chk("dtmcs_read", tdo[31:0], 32'h0000_1071);

    // DTMCS write both reset bits
    scan_dr(32, 64'h0003_0000, 0, tdo);
    chk("pulse_hi", {dmireset_o, dmihardreset_o}, 2'b11);
    step(0, 0);
    chk("pulse_lo", {dmireset_o, dmihardreset_o}, 2'b00);

    // Channel 1
    scan_ir(5'h12, irtdo);
    chk("chan1_sel", chan_select_o, 2'b10);
    scan_dr(8, 64'hA5, 0, tdo);
    exp = '0;
    for (int j = 0; j < 8; j++) exp[j] = chan_seen[j][1];
    chk("chan1_stream", tdo[7:0], exp[7:0]);
    td_i = 1'b1;
    #1;
    chk("dr_tdi", dr_tdi_o, 1);

    // Unmapped IR falls back to bypass
    scan_ir(5'h05, irtdo);
    chk("bypass_sel", chan_select_o, 2'b00);
    scan_dr(10, 64'h2D3, 0, tdo);
    chk("bypass_stream", tdo[9:0], {9'h0D3, 1'b0});

    // Five TMS=1 edges from mid-ShiftDr
    step(1, 0);
    step(0, 0);
    step(0, 0);
    step(0, 1);
    step(0, 0);
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("tms_reset_tlr", test_logic_reset_o, 1);
    chk("tms_reset_tdo", td_o, 0);
    step(0, 0);
    scan_dr(32, 64'hFFFF_FFFF, 0, tdo);
    chk("tms_reset_idcode", tdo[31:0], 32'h0000_0001);

    // trst pulse mid-ShiftIr
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    chk("shift_ir_tdo", td_o, 1);
    trst_ni = 1'b0;
    #1;
    chk("trst_tdo", td_o, 0);
    chk("trst_oe", tdo_oe_o, 0);
    chk("trst_tlr", test_logic_reset_o, 1);
    #1;
    trst_ni = 1'b1;
    step(0, 0);
    scan_dr(32, 64'h0, 0, tdo);
    chk("trst_idcode", tdo[31:0], 32'h0000_0001);

    // Random TMS walks always end in TestLogicReset after five ones
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(0, 15);
      for (int i = 0; i < n; i++) step(1'($urandom), 1'($urandom));
      for (int i = 0; i < 5; i++) step(1, 0);
      chk("walk_tlr", test_logic_reset_o, 1);
    end
    step(0, 0);

    // Randomized IR/DR scans against the model
    for (int r = 0; r < 14; r++) begin
      case ($urandom_range(0, 6))
        0: ir = 5'h00;
        1: ir = 5'h01;
        2: ir = 5'h10;
        3: ir = 5'h11;
        4: ir = 5'h12;
        5: ir = 5'h1F;
        default: ir = 5'($urandom);
      endcase
      dmistat_i = 2'($urandom);
      scan_ir(ir, irtdo);
      chk("rnd_ir_capture", irtdo, 5'b00001);
      chk("rnd_chan_sel", chan_select_o, chan_model(ir));
      len = dr_len(ir);
      cap = dr_cap(ir, dmistat_i);
      n = (len == 32) ? $urandom_range(32, 40) : $urandom_range(4, 40);
      pause_at = $urandom_range(0, 1) ? $urandom_range(1, n - 2) : 0;
      tdi = {$urandom, $urandom};
      scan_dr(n, tdi, pause_at, tdo);
      exp = '0;
      for (int j = 0; j < n; j++) begin
        if (chan_model(ir) != 2'b00) exp[j] = chan_seen[j][chan_model(ir) == 2'b10];
        else if (j < len)            exp[j] = cap[j];
        else                         exp[j] = tdi[j-len];
      end
      mask = (64'd1 << n) - 64'd1;
      chk("rnd_dr_stream", tdo & mask, exp & mask);
      if (ir == 5'h10)
        chk("rnd_pulses", {dmireset_o, dmihardreset_o}, {tdi[n-32+16], tdi[n-32+17]});
      else
        chk("rnd_no_pulses", {dmireset_o, dmihardreset_o}, 2'b00);
      step(0, 0);
      chk("rnd_pulse_lo", {dmireset_o, dmihardreset_o}, 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #60000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
